// File: rtl/bp_meta_pipe_if.sv
// Fetch/EX-side bundle for bp_meta_pipe. BP_META_PIPE_STATS_EN adds the
// br_count/mp_count statistics outputs.
interface bp_meta_pipe_if #(
  parameter int IDX_W = 10
);
  logic [31:0]      pc_if;
  logic             fetch_valid;
  logic             is_branch_if;
  logic             gshare_pred_if;
  logic             local_pred_if;
  logic             final_pred_if;
  logic             stall;
  logic             flush;
  logic             is_branch_ex;
  logic             taken_ex;
  logic [IDX_W-1:0] GPT_index;
  logic [IDX_W-1:0] GPT_index_update;
  logic [31:0]      pc_ex;
  logic             Gshare;
  logic             Local;
  logic             taken;
  logic             update;
  logic             mispredict;
`ifdef BP_META_PIPE_STATS_EN
  logic [31:0]      br_count;
  logic [31:0]      mp_count;

  modport master (
    output pc_if, fetch_valid, is_branch_if, gshare_pred_if, local_pred_if,
           final_pred_if, stall, flush, is_branch_ex, taken_ex,
    input  GPT_index, GPT_index_update, pc_ex, Gshare, Local, taken, update,
           mispredict, br_count, mp_count
  );

  modport slave (
    input  pc_if, fetch_valid, is_branch_if, gshare_pred_if, local_pred_if,
           final_pred_if, stall, flush, is_branch_ex, taken_ex,
    output GPT_index, GPT_index_update, pc_ex, Gshare, Local, taken, update,
           mispredict, br_count, mp_count
  );
`else
  modport master (
    output pc_if, fetch_valid, is_branch_if, gshare_pred_if, local_pred_if,
           final_pred_if, stall, flush, is_branch_ex, taken_ex,
    input  GPT_index, GPT_index_update, pc_ex, Gshare, Local, taken, update,
           mispredict
  );

  modport slave (
    input  pc_if, fetch_valid, is_branch_if, gshare_pred_if, local_pred_if,
           final_pred_if, stall, flush, is_branch_ex, taken_ex,
    output GPT_index, GPT_index_update, pc_ex, Gshare, Local, taken, update,
           mispredict
  );
`endif
endinterface

// File: rtl/bp_meta_pipe.sv
// Gshare/Local/chooser metadata pipeline (IF->ID->EX) with speculative GBHR
// and mispredict repair. BP_META_PIPE_STATS_EN adds branch/mispredict counters.
module bp_meta_pipe #(
  parameter int HIST_LEN = 12,
  parameter int IDX_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  bp_meta_pipe_if.slave    bus
);

  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [IDX_W-1:0]    idx;
    logic [HIST_LEN-1:0] snap;
    logic                branch;
    logic                gshare;
    logic                lcl;
    logic                fin;
  } slot_t;

  slot_t               id_r;
  slot_t               ex_r;
  slot_t               cap_s;
  slot_t               ex_adv_s;
  logic [HIST_LEN-1:0] gbhr_r;
  logic [HIST_LEN-1:0] gbhr_nxt_s;
  logic [IDX_W-1:0]    idx_s;
  logic                upd_s;
  logic                mp_s;
  logic                kill_s;
  logic                accept_s;

  // Lookup index and EX-stage resolution
  always_comb begin
    idx_s    = bus.pc_if[IDX_W+1:2] ^ gbhr_r[IDX_W-1:0];
    upd_s    = ex_r.valid & ex_r.branch & bus.is_branch_ex & ~bus.stall;
    mp_s     = upd_s & (bus.taken_ex != ex_r.fin);
    kill_s   = bus.flush | mp_s;
    accept_s = bus.fetch_valid & ~bus.stall & ~kill_s;
  end

  // IF capture and the ID->EX advance
  always_comb begin
    cap_s         = '0;
    cap_s.valid   = accept_s;
    cap_s.pc      = bus.pc_if;
    cap_s.idx     = idx_s;
    cap_s.snap    = gbhr_r;
    cap_s.branch  = bus.is_branch_if;
    cap_s.gshare  = bus.gshare_pred_if;
    cap_s.lcl     = bus.local_pred_if;
    cap_s.fin     = bus.final_pred_if;
    ex_adv_s       = id_r;
    ex_adv_s.valid = id_r.valid & ~kill_s;
  end

  // Next history: repair wins over speculative shift; shifts drop the MSB
  always_comb begin
    gbhr_nxt_s = gbhr_r;
    if (mp_s) begin
      gbhr_nxt_s = (ex_r.snap << 1) | {{(HIST_LEN-1){1'b0}}, bus.taken_ex};
    end else if (accept_s && bus.is_branch_if) begin
      gbhr_nxt_s = (gbhr_r << 1) | {{(HIST_LEN-1){1'b0}}, bus.final_pred_if};
    end else begin
      gbhr_nxt_s = gbhr_r;
    end
  end

  // Slot and history registers; a stall holds both slots but kill still empties ID
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_r   <= '0;
      ex_r   <= '0;
      gbhr_r <= '0;
    end else begin
      gbhr_r <= gbhr_nxt_s;
      if (!bus.stall) begin
        id_r <= cap_s;
        ex_r <= ex_adv_s;
      end else begin
        id_r       <= id_r;
        id_r.valid <= id_r.valid & ~kill_s;
        ex_r       <= ex_r;
      end
    end
  end

  assign bus.GPT_index        = idx_s;
  assign bus.GPT_index_update = ex_r.idx;
  assign bus.pc_ex            = ex_r.pc;
  assign bus.Gshare           = ex_r.gshare;
  assign bus.Local            = ex_r.lcl;
  assign bus.taken            = bus.taken_ex;
  assign bus.update           = upd_s;
  assign bus.mispredict       = mp_s;

`ifdef BP_META_PIPE_STATS_EN
  logic [31:0] br_cnt_r;
  logic [31:0] mp_cnt_r;

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_r <= 32'd0;
      mp_cnt_r <= 32'd0;
    end else begin
      if (upd_s && (br_cnt_r != 32'hFFFF_FFFF)) begin
        br_cnt_r <= br_cnt_r + 32'd1;
      end else begin
        br_cnt_r <= br_cnt_r;
      end
      if (mp_s && (mp_cnt_r != 32'hFFFF_FFFF)) begin
        mp_cnt_r <= mp_cnt_r + 32'd1;
      end else begin
        mp_cnt_r <= mp_cnt_r;
      end
    end
  end

  assign bus.br_count = br_cnt_r;
  assign bus.mp_count = mp_cnt_r;
`endif

endmodule

// File: tb/tb_bp_meta_pipe.sv
// Directed + random bench for bp_meta_pipe against a behavioural two-entry
// in-flight model of the metadata pipeline and global history.
module tb_bp_meta_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_meta_pipe_if #(.IDX_W(10)) bus ();
  bp_meta_pipe #(.HIST_LEN(12), .IDX_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_bad = 0;
  int seen  = 0;
  int unsigned m_br_cnt = 0;
  int unsigned m_mp_cnt = 0;

  // In-flight model: entry 0 is the younger (ID) instruction, entry 1 the older (EX)
  int unsigned ghr;
  bit          m_valid [2];
  int unsigned m_pc    [2];
  int unsigned m_snap  [2];
  bit          m_br    [2];
  bit          m_g     [2];
  bit          m_l     [2];
  bit          m_f     [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ghr = 0;
    m_br_cnt = 0;
    m_mp_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = 0; m_snap[i] = 0;
      m_br[i] = 1'b0; m_g[i] = 1'b0; m_l[i] = 1'b0; m_f[i] = 1'b0;
    end
  endtask

  task automatic set_in(input bit fv, input logic [31:0] pc, input bit br, input bit f,
                        input bit st, input bit fl, input bit bex, input bit tk);
    bus.fetch_valid    = fv;
    bus.pc_if          = pc;
    bus.is_branch_if   = br;
    bus.final_pred_if  = f;
    bus.gshare_pred_if = 1'($urandom_range(0, 1));
    bus.local_pred_if  = 1'($urandom_range(0, 1));
    bus.stall          = st;
    bus.flush          = fl;
    bus.is_branch_ex   = bex;
    bus.taken_ex       = tk;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model
  task automatic tick();
    bit e_upd, e_mp, kill, acc;
    bit c_fv, c_br, c_f, c_g, c_l, c_st, c_fl, c_tk;
    int unsigned c_pc, old_ghr;
    @(negedge clk);
    if (!rst) model_clear();
    e_upd = rst && m_valid[1] && m_br[1] && bus.is_branch_ex && !bus.stall;
    e_mp  = e_upd && (bus.taken_ex != m_f[1]);
    chk("update", 32'(bus.update), 32'(e_upd));
    chk("mispredict", 32'(bus.mispredict), 32'(e_mp));
    chk("gpt_index", 32'(bus.GPT_index), ((bus.pc_if >> 2) ^ ghr) & 32'h3FF);
    chk("taken", 32'(bus.taken), 32'(bus.taken_ex));
    if (e_upd) begin
      chk("idx_update", 32'(bus.GPT_index_update), ((m_pc[1] >> 2) ^ m_snap[1]) & 32'h3FF);
      chk("pc_ex", bus.pc_ex, m_pc[1]);
      chk("gshare", 32'(bus.Gshare), 32'(m_g[1]));
      chk("local", 32'(bus.Local), 32'(m_l[1]));
    end
    if (bus.update === 1'b1) seen++;
    c_fv = bus.fetch_valid; c_br = bus.is_branch_if; c_f = bus.final_pred_if;
    c_g = bus.gshare_pred_if; c_l = bus.local_pred_if; c_st = bus.stall;
    c_fl = bus.flush; c_tk = bus.taken_ex; c_pc = bus.pc_if;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      if (e_upd) m_br_cnt++;
      if (e_mp) m_mp_cnt++;
      kill = c_fl | e_mp;
      acc  = c_fv & ~c_st & ~kill;
      old_ghr = ghr;
      if (e_mp) ghr = ((m_snap[1] << 1) | 32'(c_tk)) & 32'hFFF;
      else if (acc && c_br) ghr = ((ghr << 1) | 32'(c_f)) & 32'hFFF;
      if (!c_st) begin
        m_valid[1] = m_valid[0] & ~kill;
        m_pc[1] = m_pc[0]; m_snap[1] = m_snap[0]; m_br[1] = m_br[0];
        m_g[1] = m_g[0]; m_l[1] = m_l[0]; m_f[1] = m_f[0];
        m_valid[0] = acc; m_pc[0] = c_pc; m_snap[0] = old_ghr; m_br[0] = c_br;
        m_g[0] = c_g; m_l[0] = c_l; m_f[0] = c_f;
      end else if (kill) begin
        m_valid[0] = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    rst = 1'b0;
    // Reset held with branch activity on every input
    set_in(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    chk("rst_update", 32'(bus.update), 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst_gbhr", 32'(bus.GPT_index), 32'h040);
    rst = 1'b1;
    set_in(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("rel_gpt_index", 32'(bus.GPT_index), 32'h004);
    tick();

    // Correctly predicted taken branch at 0x100
    set_in(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("ok_update", 32'(bus.update), 32'd1);
    chk("ok_mispredict", 32'(bus.mispredict), 32'd0);
    chk("ok_idx_update", 32'(bus.GPT_index_update), 32'h040);
    chk("ok_gbhr", 32'(bus.GPT_index), 32'h001);
    tick();
    #1 chk("ok_once", 32'(bus.update), 32'd0);
    tick();

    // Build history 0x005, then mispredict the branch fetched with that snapshot
    set_in(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h504, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("mp_mispredict", 32'(bus.mispredict), 32'd1);
    chk("mp_idx_update", 32'(bus.GPT_index_update), 32'h085);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("mp_gbhr_repair", 32'(bus.GPT_index), 32'h00A);
    chk("mp_squash", 32'(bus.update), 32'd0);
    tick(); tick();

    // Branch held in EX by a three-cycle stall
    set_in(1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    seen = 0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk("stall_hold", 32'(seen), 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("stall_release", 32'(bus.update), 32'd1);
    tick(); tick();
    chk("stall_once", 32'(seen), 32'd1);

    // Flush with branches in ID and IF
    set_in(1'b1, 32'h700, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h704, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    seen = 0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk("flush_no_update", 32'(seen), 32'd0);
    chk("flush_gbhr", 32'(bus.GPT_index), 32'h02B);

    // Reset asserted with a branch in flight
    set_in(1'b1, 32'h800, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 chk("mid_rst_update", 32'(bus.update), 32'd0);
    tick();
    rst = 1'b1;
    seen = 0;
    tick(); tick(); tick();
    chk("mid_rst_discard", 32'(seen), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3FFF), 2'b00},
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) rst = 1'b0;
      tick();
      rst = 1'b1;
    end

`ifdef BP_META_PIPE_STATS_EN
    chk("br_count_rand", bus.br_count, m_br_cnt);
    chk("mp_count_rand", bus.mp_count, m_mp_cnt);
    rst = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_in(1'b1, 32'h900 + 32'(b * 4), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (b != 1)); tick();
    end
    chk("br_count", bus.br_count, 32'd3);
    chk("mp_count", bus.mp_count, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_meta_pipe.md
BP_META_PIPE -- requirements
Module: bp_meta_pipe

Interface
REQ-001 Parameter HIST_LEN, default 12: global branch history register (GBHR) width.
REQ-002 Parameter IDX_W, default 10: predictor table index width; SHALL satisfy IDX_W <= HIST_LEN.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 pc_if  in  32  fetch-stage PC.
REQ-006 fetch_valid  in  1  valid instruction in IF this cycle.
REQ-007 is_branch_if  in  1  predecoded conditional branch in IF.
REQ-008 gshare_pred_if / local_pred_if / final_pred_if  in  1 each  Gshare, Local and chooser-selected predictions for the IF instruction.
REQ-009 stall  in  1  pipeline hold.
REQ-010 flush  in  1  external squash of younger instructions.
REQ-011 is_branch_ex  in  1  EX instruction is a resolved conditional branch.
REQ-012 taken_ex  in  1  actual branch outcome in EX.
REQ-013 GPT_index  out  IDX_W  lookup index for IF.
REQ-014 GPT_index_update, pc_ex, Gshare, Local, taken, update  out  IDX_W/32/1/1/1/1  EX-stage metadata feeding the predictor and chooser update ports.
REQ-015 mispredict  out  1  EX branch outcome differs from final_pred.

Function
REQ-016 GPT_index SHALL be combinational: pc_if[IDX_W+1:2] XOR GBHR[IDX_W-1:0].
REQ-017 Two metadata slots (ID, EX), each: valid, pc[31:0], idx, GBHR snapshot (pre-shift), branch flag, gshare, local, final.
REQ-018 accept = fetch_valid & ~stall & ~kill, where kill = flush | mispredict.
REQ-019 stall=0: ID slot <= IF capture (valid=accept); EX slot <= ID slot with valid = ID.valid & ~kill.
REQ-020 stall=1: both slots SHALL hold, except kill SHALL clear ID.valid.
REQ-021 update SHALL equal EX.valid & EX.branch & is_branch_ex & ~stall, so each branch is reported in exactly one cycle.
REQ-022 GPT_index_update, pc_ex, Gshare, Local SHALL be driven from the EX slot; taken SHALL be taken_ex passed through.
REQ-023 mispredict SHALL equal update & (taken_ex != EX.final); combinational, same cycle as update.
REQ-024 GBHR speculative shift: on accept & is_branch_if, GBHR <= {GBHR[HIST_LEN-2:0], final_pred_if}.
REQ-025 GBHR repair: on mispredict, GBHR <= {EX.snapshot[HIST_LEN-2:0], taken_ex}; repair SHALL take priority over the speculative shift in the same cycle.
REQ-026 Non-branch fetches SHALL leave GBHR unchanged.
REQ-027 Index arithmetic SHALL be modulo 2^IDX_W; GBHR shift SHALL discard the MSB (no saturation).
REQ-028 Back-to-back branches: the ID-slot branch SHALL be squashed when an older EX branch mispredicts in the same cycle.

Reset
REQ-029 While rst=0: all slot valids, GBHR, and counters SHALL be 0; update=0 and mispredict=0 regardless of other inputs.
REQ-030 Reset asserted mid-operation SHALL discard in-flight metadata; no update SHALL be emitted for it after release.
REQ-031 First posedge after rst release SHALL behave as a normal cycle.

Configuration
REQ-032 Macro BP_META_PIPE_STATS_EN: when defined, adds outputs br_count[31:0] and mp_count[31:0], incremented on update and on mispredict respectively, saturating at 0xFFFFFFFF, reset to 0; when undefined, neither port nor counter logic SHALL exist and all other behaviour SHALL be identical.

Verification
REQ-033 Reset: rst=0 with fetch_valid=1, is_branch_if=1 -> GBHR=0, update=0, mispredict=0; after release, pc_if=0x00000010 -> GPT_index=0x004.
REQ-034 Correct prediction: branch at 0x100, final_pred_if=1, taken_ex=1 two cycles later -> update=1 for one cycle, mispredict=0, GPT_index_update=0x040, GBHR=0x001.
REQ-035 Mispredict repair: snapshot 0x005, final=1, taken_ex=0 -> mispredict=1, GBHR=0x00A next cycle, younger ID branch squashed (no update for it).
REQ-036 Stall: branch in EX with stall=1 for 3 cycles, then 0 -> update asserted exactly once, in the release cycle.
REQ-037 Flush: flush=1 with branches in ID and IF -> neither produces update; GBHR unchanged by the flushed IF branch.
REQ-038 BP_META_PIPE_STATS_EN: 3 branches, 1 mispredicted -> br_count=3, mp_count=1; build without macro compiles and passes REQ-033..037.
